// File: rtl/tiny_cpu_core.sv
// ---------------------------------------------------------------------------
// tiny_cpu_core
//   Single-cycle accumulator-style CPU: four DW-bit registers, a combinationally
//   read instruction memory (8-bit words) and data memory, an IDLE/RUN/HALT
//   control FSM, a host load port and a debug register read.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin execution at PC 0 (IDLE/HALT only)
//   stall           freeze every RUN-state update while high
//   prog_we         host write strobe (IDLE/HALT only)
//   prog_dsel       0 = instruction memory, 1 = data memory
//   prog_addr       host write address, modulo the selected depth
//   prog_data       host write data (imem keeps bits [7:0])
//   dbg_sel         register index shown on dbg_data
//   dbg_data        combinational regfile[dbg_sel]
//   pc              current PC, zero-extended to 4 bits
//   running/halted  FSM status
//   instr_count     retired instructions since last start, saturating
// ---------------------------------------------------------------------------
module tiny_cpu_core #(
    parameter int DW         = 8,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    input  logic          prog_we,
    input  logic          prog_dsel,
    input  logic [3:0]    prog_addr,
    input  logic [DW-1:0] prog_data,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_data,
    output logic [3:0]    pc,
    output logic          running,
    output logic          halted,
    output logic [15:0]   instr_count
);

    localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_ALU = 2'b10;
    localparam logic [1:0] OP_JZ  = 2'b11;

    logic [1:0]     state_reg;
    logic [IAW-1:0] pc_reg;
    logic [15:0]    count_reg;
    logic [DW-1:0]  regs_reg [4];
    logic [7:0]     imem [IMEM_DEPTH];
    logic [DW-1:0]  dmem_rd [DMEM_DEPTH];

    // Decode of the instruction currently addressed by the PC
    logic [7:0]     instr;
    logic [1:0]     op;
    logic [1:0]     ra;
    logic [1:0]     rb;
    logic [1:0]     func;
    logic [3:0]     imm4;
    logic [DAW-1:0] d_idx;
    logic [IAW-1:0] j_target;
    logic [DW-1:0]  ra_val;
    logic [DW-1:0]  rb_val;

    assign instr    = imem[pc_reg];
    assign op       = instr[7:6];
    assign ra       = instr[5:4];
    assign rb       = instr[3:2];
    assign func     = instr[1:0];
    assign imm4     = instr[3:0];
    assign d_idx    = imm4[DAW-1:0];
    assign j_target = imm4[IAW-1:0];
    assign ra_val   = regs_reg[ra];
    assign rb_val   = regs_reg[rb];

    logic host_ok;
    logic exec;
    logic jz_taken;
    logic halt_hit;
    logic [IAW-1:0] pc_next;
    logic           reg_we;
    logic [DW-1:0]  reg_wdata;
    logic           imem_we;
    logic           dmem_host_we;
    logic           dmem_st_we;

    assign host_ok      = (state_reg != S_RUN);
    assign exec         = (state_reg == S_RUN) && !stall;
    assign jz_taken     = (op == OP_JZ) && (ra_val == '0);
    // A taken jump onto itself is the halt idiom; it still retires.
    assign halt_hit     = jz_taken && (j_target == pc_reg);
    assign pc_next      = jz_taken ? j_target : pc_reg + IAW'(1);
    assign imem_we      = host_ok && prog_we && !prog_dsel;
    assign dmem_host_we = host_ok && prog_we && prog_dsel;
    assign dmem_st_we   = exec && (op == OP_ST);

    always_comb begin
        reg_we    = 1'b0;
        reg_wdata = '0;
        case (op)
            OP_LD: begin
                reg_we    = 1'b1;
                reg_wdata = dmem_rd[d_idx];
            end
            OP_ALU: begin
                reg_we = 1'b1;
                case (func)
                    2'b00:   reg_wdata = ra_val + rb_val;
                    2'b01:   reg_wdata = ra_val - rb_val;
                    2'b10:   reg_wdata = ra_val & rb_val;
                    default: reg_wdata = ra_val ^ rb_val;
                endcase
            end
            default: begin
                reg_we    = 1'b0;
                reg_wdata = '0;
            end
        endcase
    end

    // Instruction memory: no reset, so contents survive a reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[prog_addr[IAW-1:0]] <= prog_data[7:0];
        end
    end

    // Data memory words: cleared by reset, written by host or by ST.
    // Host and ST writes are mutually exclusive because they need
    // different FSM states.
    generate
        for (genvar gi = 0; gi < DMEM_DEPTH; gi++) begin : g_dmem
            logic [DW-1:0] word_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (dmem_host_we && prog_addr[DAW-1:0] == DAW'(gi)) begin
                    word_reg <= prog_data;
                end else if (dmem_st_we && d_idx == DAW'(gi)) begin
                    word_reg <= ra_val;
                end
            end
            assign dmem_rd[gi] = word_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            pc_reg    <= '0;
            count_reg <= '0;
            for (int i = 0; i < 4; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state_reg <= S_RUN;
                        pc_reg    <= '0;
                        count_reg <= '0;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        pc_reg <= pc_next;
                        if (count_reg != 16'hFFFF) begin
                            count_reg <= count_reg + 16'd1;
                        end
                        if (halt_hit) begin
                            state_reg <= S_HALT;
                        end
                        if (reg_we) begin
                            regs_reg[ra] <= reg_wdata;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign dbg_data    = regs_reg[dbg_sel];
    assign pc          = 4'(pc_reg);
    assign running     = (state_reg == S_RUN);
    assign halted      = (state_reg == S_HALT);
    assign instr_count = count_reg;

    // Address/immediate bits above the configured memory depths are don't-care.
    logic unused_bits;
    assign unused_bits = ^{prog_addr, imm4};

endmodule

// File: doc/tiny_cpu_core.md
Name: tiny_cpu_core

Overview:
- Parametrised single-cycle accumulator-style CPU core: 4 general registers, separate instruction and data memories, and a host load port.
- Adds over the previous generation: configurable data width and memory depths, an explicit IDLE/RUN/HALT control FSM, host program/data loading, a stall input, a retired-instruction counter and a debug register read.
- Sits under the top-level pin wrapper. The wrapper maps pins onto the host load port and the debug outputs.

Parameters:
- DW, 8, data/register width in bits; legal range 8..16. Instruction words are always 8 bits wide.
- IMEM_DEPTH, 16, instruction words; power of two, 2..16.
- DMEM_DEPTH, 16, data words; power of two, 2..16.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  pulse: begin execution at PC 0 (accepted in IDLE or HALT only).
- stall  in  1  freezes all RUN-state updates while high.
- prog_we  in  1  host write strobe (honoured in IDLE or HALT only).
- prog_dsel  in  1  0 = instruction memory, 1 = data memory.
- prog_addr  in  4  host write address, taken modulo the selected depth.
- prog_data  in  DW  host write data; instruction memory takes bits [7:0].
- dbg_sel  in  2  register index for dbg_data.
- dbg_data  out  DW  combinational read of regfile[dbg_sel].
- pc  out  4  current PC, zero-extended from log2(IMEM_DEPTH) bits.
- running  out  1  high in RUN.
- halted  out  1  high in HALT.
- instr_count  out  16  retired instructions since last start; saturates at 0xFFFF.

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- On reset:
  - state = IDLE, PC = 0, regs = 0, dmem = 0, instr_count = 0.
  - running = 0, halted = 0.
  - imem has no reset; its contents are undefined until loaded.
- Instruction format: [7:6] opcode, [5:4] rA, [3:2] rB, [1:0] func, [3:0] imm4.
- Opcodes:
  - 00 LD: rA <= dmem[imm4 mod DMEM_DEPTH].
  - 01 ST: dmem[imm4 mod DMEM_DEPTH] <= rA.
  - 10 ALU: rA <= rA op rB.
    - func 00 ADD, 01 SUB, 10 AND, 11 XOR.
    - Result is mod 2^DW; written back at the same edge (no delayed result register).
  - 11 JZ: if rA == 0, PC <= imm4 mod IMEM_DEPTH, else PC + 1.
- Non-jump instructions set PC <= PC + 1, wrapping IMEM_DEPTH-1 -> 0.
- FSM:
  - IDLE: start=1 -> RUN with PC=0 and instr_count=0.
  - RUN: each clk edge with stall=0 executes imem[PC] and increments instr_count (saturating).
    - stall=1: no state, PC, register, memory or counter change.
  - RUN -> HALT: a JZ that is taken and whose target equals the current PC. It retires and is counted; PC stays put.
  - HALT: start=1 -> RUN with PC=0 and instr_count=0. Registers and dmem are preserved.
  - start in RUN is ignored. There is no other exit from RUN except reset.
- Host writes:
  - prog_we in IDLE/HALT writes memory at the edge.
  - prog_we in RUN is ignored entirely (no write, no side effect).
  - prog_we and start in the same cycle: the write commits at that edge, then the first RUN fetch sees the new contents.
- Reads of imem and dmem are combinational (asynchronous) within the cycle.
- ST followed by LD of the same address in the next instruction returns the stored value.
- Reset asserted mid-RUN: immediate return to IDLE; regs, dmem and the counter are cleared; imem is kept.

Test Plan:
- Reset check: assert rst_n=0 mid-run, then release -> running=0, halted=0, pc=0, instr_count=0, dbg_data=0 for all dbg_sel values.
- Add/store (DW=8):
  - Stimulus: dmem[0]=5, dmem[1]=3; imem = 0x10, 0x21, 0x98, 0x52, 0xC4; then start.
  - Required: halted after 5 retired instructions; r1=8, r2=3, pc=4, instr_count=5.
  - A follow-up program LD r3,[2] then halt gives r3=8.
- SUB wrap: dmem[0]=3, dmem[1]=5; imem = 0x10, 0x21, 0x99, 0xC3 -> r1=0xFE, instr_count=4.
- Countdown loop:
  - Stimulus: dmem[0]=3, dmem[1]=1; imem = 0x10, 0x21, 0xD5, 0x99, 0xC2, 0xC5.
  - Required: r1=0, halted, pc=5, instr_count=13.
  - Rerun with stall held for 4 cycles mid-loop -> same final state, instr_count=13.
- Load lockout: prog_we to imem[2] during RUN -> ignored; the program result is unchanged. The same write in HALT followed by start -> the new program runs.
- Variant DW=16, IMEM_DEPTH=8: program of seven 0x98 words then JZ r0,7 with r1=0xFFFF, r2=1 -> r1 wraps to 0x0006, instr_count=8. A program without halt checks that the PC wraps 7 -> 0.
